// File: rtl/pwm_ramp_sequencer_if.sv
// rtl/pwm_ramp_sequencer_if.sv - switch pulses in, setpoint/duty/motor status out
interface pwm_ramp_sequencer_if #(
  parameter int DUTY_W = 7
);
  logic              swt_increase;
  logic              swt_decrease;
  logic              swt_start_stop;
  logic [DUTY_W-1:0] setpoint;
  logic [DUTY_W-1:0] duty_out;
  logic              motor_running;
  logic              ramping;
  logic [1:0]        state;

  modport master (
    output swt_increase, swt_decrease, swt_start_stop,
    input  setpoint, duty_out, motor_running, ramping, state
  );

  modport slave (
    input  swt_increase, swt_decrease, swt_start_stop,
    output setpoint, duty_out, motor_running, ramping, state
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// rtl/pwm_ramp_sequencer.sv - soft-start/soft-stop duty ramp sequencer with 4-state motor FSM
module pwm_ramp_sequencer #(
  parameter int DUTY_W   = 7,
  parameter int DUTY_MAX = 100,
  parameter int STEP     = 10,
  parameter int SP_INIT  = 50,
  parameter int RAMP_DIV = 50000
) (
  input logic                clk,
  input logic                rst,
  pwm_ramp_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [DUTY_W-1:0] STEP_N  = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] MAX_N   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_N  = DUTY_W'(SP_INIT);
  localparam logic [DUTY_W-1:0] ONE_N   = DUTY_W'(1);
  localparam logic [DUTY_W:0]   STEP_W1 = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0]   MAX_W1  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W:0]   sp_sum;
  logic              tick;

  assign tick   = (state_q != IDLE) && (cnt_q == CNT_TOP);
  assign sp_sum = {1'b0, sp_q} + STEP_W1;

  // Setpoint next value: saturating step, opposing pulses cancel
  always_comb begin
    sp_d = sp_q;
    if (bus.swt_increase && !bus.swt_decrease) begin
      sp_d = (sp_sum > MAX_W1) ? MAX_N : sp_sum[DUTY_W-1:0];
    end else if (bus.swt_decrease && !bus.swt_increase) begin
      sp_d = (sp_q < STEP_N) ? '0 : (sp_q - STEP_N);
    end
  end

  // Motor FSM next state and duty; start_stop outranks completion
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (bus.swt_start_stop) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (bus.swt_start_stop) begin
          state_d = RAMP_DOWN;
        end else if (duty_q >= sp_q) begin
          // Setpoint may have dropped below the applied duty mid-ramp
          state_d = RUN;
          duty_d  = sp_q;
        end else if (tick) begin
          duty_d = duty_q + ONE_N;
        end
      end
      RUN: begin
        if (bus.swt_start_stop) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          if (duty_q < sp_q)      duty_d = duty_q + ONE_N;
          else if (duty_q > sp_q) duty_d = duty_q - ONE_N;
        end
      end
      RAMP_DOWN: begin
        if (bus.swt_start_stop) begin
          state_d = RAMP_UP;
        end else if (duty_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          duty_d = duty_q - ONE_N;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick divider restarts on every state change and rests in IDLE
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (state_d != state_q || state_q == IDLE || tick) cnt_d = '0;
  end

  // State, duty, setpoint and divider registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      sp_q    <= INIT_N;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.duty_out      = duty_q;
  assign bus.setpoint      = sp_q;
  assign bus.motor_running = (state_q != IDLE);
  assign bus.ramping       = (state_q != IDLE) &&
                             (duty_q != ((state_q == RAMP_DOWN) ? '0 : sp_q));

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb/tb_pwm_ramp_sequencer.sv - randomized check of pwm_ramp_sequencer against a behavioural model
module tb_pwm_ramp_sequencer;

  localparam int RAMP_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pwm_ramp_sequencer_if #(.DUTY_W(7)) bus ();

  pwm_ramp_sequencer #(
    .DUTY_W(7), .DUTY_MAX(100), .STEP(10), .SP_INIT(50), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: motor phase 0..3, percent setpoint/duty, cycles since phase entry
  int m_state = 0;
  int m_sp    = 50;
  int m_duty  = 0;
  int m_age   = 0;
  int t_sp, t_state, t_duty, t_age;
  bit t_tick;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0; m_sp <= 50; m_duty <= 0; m_age <= 0;
    end else begin
      t_sp = m_sp;
      if (bus.swt_increase && !bus.swt_decrease) t_sp = (m_sp + 10 > 100) ? 100 : m_sp + 10;
      if (bus.swt_decrease && !bus.swt_increase) t_sp = (m_sp - 10 < 0) ? 0 : m_sp - 10;
      t_tick  = (m_state != 0) && ((m_age % RAMP_DIV) == RAMP_DIV - 1);
      t_state = m_state;
      t_duty  = m_duty;
      if (m_state == 0) begin
        t_duty = 0;
        if (bus.swt_start_stop) t_state = 1;
      end else if (bus.swt_start_stop) begin
        t_state = (m_state == 3) ? 1 : 3;
      end else if (m_state == 1 && m_duty >= m_sp) begin
        t_state = 2; t_duty = m_sp;
      end else if (m_state == 3 && m_duty == 0) begin
        t_state = 0;
      end else if (t_tick) begin
        if (m_state == 3)            t_duty = m_duty - 1;
        else if (m_duty < m_sp)      t_duty = m_duty + 1;
        else if (m_duty > m_sp)      t_duty = m_duty - 1;
      end
      t_age = (t_state != m_state || m_state == 0) ? 0 : m_age + 1;
      m_state <= t_state; m_sp <= t_sp; m_duty <= t_duty; m_age <= t_age;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en && rst) begin
      check("state", int'(bus.state), m_state);
      check("setpoint", int'(bus.setpoint), m_sp);
      check("duty_out", int'(bus.duty_out), m_duty);
      check("motor_running", int'(bus.motor_running), int'(m_state != 0));
      check("ramping", int'(bus.ramping),
            int'(m_state != 0 && m_duty != ((m_state == 3) ? 0 : m_sp)));
    end
  end

  // Call just after a negedge; the pulse is sampled on the next posedge
  task automatic pulse(input bit inc, input bit dec, input bit ss);
    #1;
    bus.swt_increase = inc; bus.swt_decrease = dec; bus.swt_start_stop = ss;
    @(negedge clk);
    #1;
    bus.swt_increase = 1'b0; bus.swt_decrease = 1'b0; bus.swt_start_stop = 1'b0;
  endtask

  task automatic wait_for(input string name, input int st, input int duty, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (int'(bus.state) == st && int'(bus.duty_out) == duty) hit = 1'b1;
    end
    check(name, int'(hit), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.swt_increase = 1'b0; bus.swt_decrease = 1'b0; bus.swt_start_stop = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    check("rst_state", int'(bus.state), 0);
    check("rst_setpoint", int'(bus.setpoint), 50);
    check("rst_duty", int'(bus.duty_out), 0);
    check("rst_motor", int'(bus.motor_running), 0);

    pulse(0, 0, 1);
    check("start_state", int'(bus.state), 1);
    check("start_motor", int'(bus.motor_running), 1);
    wait_for("ramp_up_to_run", 2, 50, 230);
    check("run_ramping", int'(bus.ramping), 0);

    for (int i = 0; i < 6; i++) begin @(negedge clk); pulse(1, 0, 0); end
    check("sp_saturate_hi", int'(bus.setpoint), 100);
    wait_for("duty_to_100", 2, 100, 230);
    for (int i = 0; i < 5; i++) begin @(negedge clk); pulse(0, 1, 0); end
    check("sp_back_50", int'(bus.setpoint), 50);
    wait_for("duty_to_50", 2, 50, 230);

    @(negedge clk); pulse(0, 0, 1);
    check("stop_state", int'(bus.state), 3);
    wait_for("down_at_20", 3, 20, 200);
    pulse(0, 0, 1);
    check("reverse_state", int'(bus.state), 1);
    check("reverse_duty", int'(bus.duty_out), 20);
    wait_for("up_from_20", 1, 21, 10);

    @(negedge clk); pulse(0, 0, 1);
    wait_for("down_at_0", 3, 0, 200);
    pulse(0, 0, 1);
    check("ss_beats_idle", int'(bus.state), 1);
    @(negedge clk); pulse(0, 0, 1);
    wait_for("back_to_idle", 0, 0, 20);
    check("idle_motor", int'(bus.motor_running), 0);

    for (int i = 0; i < 6; i++) begin @(negedge clk); pulse(0, 1, 0); end
    check("sp_saturate_lo", int'(bus.setpoint), 0);
    for (int i = 0; i < 3; i++) begin @(negedge clk); pulse(1, 0, 0); end
    @(negedge clk); pulse(1, 1, 0);
    check("sp_inc_dec_same", int'(bus.setpoint), 30);

    // Random pulses, mostly setpoint moves with occasional start/stop
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1;
      bus.swt_increase   = ($urandom_range(0, 99) < 6);
      bus.swt_decrease   = ($urandom_range(0, 99) < 6);
      bus.swt_start_stop = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    #1;
    bus.swt_increase = 1'b0; bus.swt_decrease = 1'b0; bus.swt_start_stop = 1'b0;

    do_reset();
    pulse(0, 0, 1);
    wait_for("up_at_30", 1, 30, 200);
    #2;
    rst = 1'b0;
    #1;
    check("async_state", int'(bus.state), 0);
    check("async_duty", int'(bus.duty_out), 0);
    check("async_setpoint", int'(bus.setpoint), 50);
    check("async_motor", int'(bus.motor_running), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
